alu_nibble_sequencer: RTL and testbench
=======================================

# alu_nibble_sequencer

Multi-cycle controller that runs 8-bit operations through the 4-bit ALU datapath by issuing the low nibble, then the high nibble, with carry chained between passes. A single start/done handshake accepts operands and produces a registered 8-bit result with Z/N/C/V flags. It sits between the input switch/bidirectional pins and the 4-bit ALU core. It replaces direct nibble-wide use of the ALU when byte-wide arithmetic is needed.

## Interface
Parameters:
- none; operand width is fixed at 8 bits (two nibble passes).

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  request; sampled only when state is IDLE or DONE
- `op_a`  in  8  operand A, latched on accepted start
- `op_b`  in  8  operand B, latched on accepted start
- `func`  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101/110/111 pass A; latched on accepted start
- `busy`  out  1  high in LOW and HIGH states
- `done`  out  1  one-cycle pulse; result/flags valid from this cycle
- `result`  out  8  registered result, held until next completion
- `flag_z`  out  1  result == 0x00
- `flag_n`  out  1  result[7]
- `flag_c`  out  1  carry out of bit 7 (add/sub only, else 0); for sub, 1 = no borrow
- `flag_v`  out  1  signed overflow at bit 7 (add/sub only, else 0)

## Operation
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: `start`=1 → latch op_a/op_b/func, go LOW; else stay.
- LOW: ALU on a[3:0], b[3:0]; carry-in = 1 for sub, 0 otherwise; B inverted for sub. Store low nibble and carry-out in staging regs. Go HIGH.
- HIGH: ALU on a[7:4], b[7:4] (B inverted for sub); carry-in = staged carry. Write `result` = {high, staged low} and all four flags at once. Go DONE.
- DONE: `done`=1. If `start`=1, accept new op and go LOW; else go IDLE.
- Logic and pass functions still take both passes. Carry is ignored for them; C and V are forced to 0.
- `start` in LOW/HIGH is ignored, with no queueing. Operand/func changes after acceptance have no effect.
- `result` never shows a partially updated value. It changes only on the HIGH→DONE edge.

## Timing
- Reset (async assert): state IDLE, `busy`=0, `done`=0, `result`=0x00, all flags 0, staging regs 0. Deassertion is synchronous to `clk` in its effect: the first accepted start is at the first rising edge with `reset`=0.
- Latency: start accepted at edge E0 → LOW after E0, HIGH after E1, DONE after E2 (`done`=1, result valid) → IDLE/LOW after E3.
- Throughput: back-to-back start held high gives one result every 3 cycles.
- `busy` is 0 in DONE, so a new start is legal in the done cycle.
- Reset mid-operation (LOW or HIGH) aborts the operation. There is no `done` pulse, and `result` and the flags return to 0.

## Structure
- Package `alu_seq_pkg`: func code constants (F_ADD..F_PASS) and the FSM state enum.
- Sub-module `alu4_core`: combinational 4-bit ALU (add/sub/and/or/xor/pass).
  - Takes an explicit carry-in port instead of deriving carry from func, so chaining is possible.
  - Outputs: Y, C_out, V.
- Top: FSM, operand/func latches, staging regs, result/flag regs.

## Test plan
- Add: op_a=0x7F, op_b=0x01, func=000 → `done` 3 cycles after start; result=0x80, N=1, V=1, C=0, Z=0.
- Sub with borrow: 0x00 − 0x01, func=001 → result=0xFF, N=1, C=0, V=0.
- Sub to zero: 0x35 − 0x35 → result=0x00, Z=1, C=1, V=0.
- Logic: 0xF0 and 0x3C → 0x30, C=0, V=0. Then func=101 with op_a=0xA5 → result=0xA5, N=1.
- Start pulses in LOW and HIGH, with changed operands, are ignored and the first result is unchanged. A start held high across DONE → second `done` exactly 3 cycles after the first.
- Assert `reset` during HIGH → no `done`; all outputs 0 the same cycle. The next start completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-wide sequencer around the 4-bit ALU core:
// function codes and the controller state encoding.
package alu_seq_pkg;

  localparam logic [2:0] F_ADD  = 3'b000;
  localparam logic [2:0] F_SUB  = 3'b001;
  localparam logic [2:0] F_AND  = 3'b010;
  localparam logic [2:0] F_OR   = 3'b011;
  localparam logic [2:0] F_XOR  = 3'b100;
  localparam logic [2:0] F_PASS = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_arith(input logic [2:0] f);
    return (f == F_ADD) || (f == F_SUB);
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer_alu4_core.sv
// Combinational 4-bit ALU. Carry-in is an explicit port so nibble passes can be
// chained; for subtract B is inverted here and the caller supplies the +1.
module alu4_core
  import alu_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] func,
  input  logic       carry_in,
  output logic [3:0] y,
  output logic       c_out,
  output logic       v
);

  logic [3:0] b_eff;
  logic [4:0] sum;

  always_comb begin
    b_eff = (func == F_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, carry_in};
    y     = a;
    c_out = 1'b0;
    v     = 1'b0;
    case (func)
      F_ADD, F_SUB: begin
        y     = sum[3:0];
        c_out = sum[4];
        v     = (a[3] == b_eff[3]) && (sum[3] != a[3]);
      end
      F_AND:   y = a & b;
      F_OR:    y = a | b;
      F_XOR:   y = a ^ b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Runs 8-bit operations through alu4_core as a low-nibble pass then a
// high-nibble pass with chained carry; result and flags update atomically.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [2:0] func,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_c,
  output logic       flag_v
);

  state_t     state, state_next;
  logic [7:0] a_reg, b_reg;
  logic [2:0] func_reg;
  logic [3:0] low_reg;
  logic       carry_reg;
  logic       accept;

  logic [3:0] alu_a, alu_b, alu_y;
  logic       alu_cin, alu_cout, alu_v;

  alu4_core u_core (
    .a        (alu_a),
    .b        (alu_b),
    .func     (func_reg),
    .carry_in (alu_cin),
    .y        (alu_y),
    .c_out    (alu_cout),
    .v        (alu_v)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    alu_a      = a_reg[3:0];
    alu_b      = b_reg[3:0];
    alu_cin    = (func_reg == F_SUB);
    case (state)
      S_IDLE: begin
        accept = start;
        if (start) state_next = S_LOW;
      end
      S_LOW: begin
        busy       = 1'b1;
        state_next = S_HIGH;
      end
      S_HIGH: begin
        busy       = 1'b1;
        alu_a      = a_reg[7:4];
        alu_b      = b_reg[7:4];
        alu_cin    = carry_reg;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        accept     = start;
        state_next = start ? S_LOW : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      func_reg  <= '0;
      low_reg   <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_reg    <= op_a;
        b_reg    <= op_b;
        func_reg <= func;
      end
      if (state == S_LOW) begin
        low_reg   <= alu_y;
        carry_reg <= alu_cout;
      end
      // Whole byte and all flags commit together so result is never half-updated.
      if (state == S_HIGH) begin
        result <= {alu_y, low_reg};
        flag_z <= ({alu_y, low_reg} == 8'h00);
        flag_n <= alu_y[3];
        flag_c <= is_arith(func_reg) & alu_cout;
        flag_v <= is_arith(func_reg) & alu_v;
      end
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer: directed scenarios plus random
// operations compared against a byte-level arithmetic reference model.
module tb_alu_nibble_sequencer;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] op_a, op_b;
  logic [2:0] func;
  logic       busy, done, flag_z, flag_n, flag_c, flag_v;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  alu_nibble_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .func   (func),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_c (flag_c),
    .flag_v (flag_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {v, c, n, z, result} from plain signed/unsigned byte arithmetic.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] f);
    int ua, ub, sa, sb, sr;
    logic [7:0] y;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0;
    case (f)
      3'd0: begin
        y = 8'(ua + ub); c = (ua + ub) > 255;
        sr = sa + sb; v = (sr > 127) || (sr < -128);
      end
      3'd1: begin
        y = 8'(ua - ub); c = (ua >= ub);
        sr = sa - sb; v = (sr > 127) || (sr < -128);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      default: y = a;
    endcase
    return {v, c, y[7], (y == 8'h00), y};
  endfunction

  task automatic check_outputs(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] f);
    logic [11:0] e;
    e = model(a, b, f);
    check({tag, ".result"}, 32'(result), 32'(e[7:0]));
    check({tag, ".z"}, 32'(flag_z), 32'(e[8]));
    check({tag, ".n"}, 32'(flag_n), 32'(e[9]));
    check({tag, ".c"}, 32'(flag_c), 32'(e[10]));
    check({tag, ".v"}, 32'(flag_v), 32'(e[11]));
  endtask

  // Issue one op and return at 1 time unit after the edge where done rises.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] f);
    int lat;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; func = f;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'd3);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check_outputs(tag, a, b, f);
  endtask

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; func = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    @(negedge clk); reset = 1'b0;

    run_op("add_ovf", 8'h7F, 8'h01, 3'b000);
    run_op("sub_borrow", 8'h00, 8'h01, 3'b001);
    run_op("sub_zero", 8'h35, 8'h35, 3'b001);
    run_op("and", 8'hF0, 8'h3C, 3'b010);
    run_op("pass", 8'hA5, 8'h5A, 3'b101);
    run_op("add_carry", 8'hFF, 8'h01, 3'b000);
    run_op("sub_vneg", 8'h80, 8'h01, 3'b001);

    // Start pulses with different operands during LOW and HIGH must be ignored.
    @(negedge clk);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; func = 3'b000;
    @(posedge clk); #1;
    op_a = 8'hFF; op_b = 8'hFF; func = 3'b001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign.done", 32'(done), 32'd1);
    check_outputs("ign", 8'h12, 8'h34, 3'b000);
    @(posedge clk); #1;
    check("ign.noqueue_busy", 32'(busy), 32'd0);
    check("ign.noqueue_done", 32'(done), 32'd0);

    // Start held across DONE: second done exactly 3 cycles after the first.
    @(negedge clk);
    start = 1'b1; op_a = 8'h10; op_b = 8'h20; func = 3'b000;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    check("held.first_lat", 32'(lat), 32'd3);
    check_outputs("held1", 8'h10, 8'h20, 3'b000);
    op_a = 8'h05; op_b = 8'h03; func = 3'b001;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (done) begin lat = k; break; end
    end
    check("held.second_lat", 32'(lat), 32'd3);
    check_outputs("held2", 8'h05, 8'h03, 3'b001);

    // Reset in HIGH aborts: outputs clear immediately, no done pulse.
    run_op("pre_abort", 8'h7F, 8'h01, 3'b000);
    @(negedge clk);
    start = 1'b1; op_a = 8'h22; op_b = 8'h11; func = 3'b000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort.in_high", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort.result", 32'(result), 32'd0);
    check("abort.flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("abort.no_done", 32'(done), 32'd0);
    @(negedge clk); reset = 1'b0;
    run_op("post_abort", 8'h22, 8'h11, 3'b000);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic [2:0] rf;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rf = 3'($urandom_range(0, 7));
      run_op("rand", ra, rb, rf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
